// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine with the architectural HI/LO register pair.
// Serial shift-add multiply and restoring divide, one result bit per cycle.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_uns_q, dz_q, neg_lo_q, neg_hi_q;
  logic               done_q, div_zero_q;
  logic [WIDTH-1:0]   a_q, b_q, opnd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic               launch, a_neg, b_neg, b_zero_div;
  logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    launch     = (state_q == S_IDLE) && start && (op[3:2] == 2'b11);
    a_neg      = !is_uns_q && a_q[WIDTH-1];
    b_neg      = !is_uns_q && b_q[WIDTH-1];
    a_mag      = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag      = b_neg ? (~b_q + 1'b1) : b_q;
    b_zero_div = is_div_q && (b_q == '0);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient bits}, shifting left; diff MSB is the borrow.
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    if (dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (launch) state_d = S_PREP;
      S_PREP: state_d = b_zero_div ? S_FIX : S_ITER;
      S_ITER: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q   <= 1'b0;
      is_uns_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= (state_q == S_FIX);
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            a_q        <= a;
            b_q        <= b;
            is_div_q   <= op[1];
            is_uns_q   <= op[0];
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
        S_PREP: begin
          dz_q     <= b_zero_div;
          neg_lo_q <= a_neg ^ b_neg;
          neg_hi_q <= a_neg;
          cnt_q    <= CW'(WIDTH);
          if (is_div_q) begin
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
            opnd_q <= b_mag;
          end else begin
            acc_q  <= {{WIDTH{1'b0}}, b_mag};
            opnd_q <= a_mag;
          end
        end
        S_ITER: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
          if (dz_q) div_zero_q <= 1'b1;
        end
        default: ;
      endcase
      // mthi/mtlo land only while idle; an accepted start on the same edge does not block them.
      if (state_q == S_IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized checks of hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0, wdata = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int            tests = 0, fails = 0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;
  bit            m_dz = 1'b0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    case (o)
      4'b1100: p = 64'(sx * sy);
      4'b1101: p = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == '0) begin
          p  = {x, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (o == 4'b1110) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Launch one op, optionally with a same-edge mthi, optionally with an ignored start+mthi/mtlo at
  // cycle 'intrude_at' of the operation; check latency, busy length, held HI/LO and the result.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input bit with_mthi, input int intrude_at);
    logic [W-1:0] eh, el;
    bit edz;
    int lat, cyc, busy_cnt;
    model(o, x, y, eh, el, edz);
    lat   = edz ? 2 : W + 2;
    start = 1'b1; op = o; a = x; b = y;
    if (with_mthi) begin
      hi_we = 1'b1; wdata = 32'h0000_00AA; m_hi = 32'h0000_00AA;
    end
    tick();
    start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    check({tag, "/busy_at_start"}, 64'(busy), 64'(1));
    check({tag, "/hi_held"}, 64'(hi), 64'(m_hi));
    check({tag, "/dz_cleared"}, 64'(div_zero), 64'(0));
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc <= 100) begin
      if (intrude_at != 0 && cyc == intrude_at) begin
        start = 1'b1; op = 4'b1111; a = 32'h55; b = 32'h3;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_00AA;
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({tag, "/intrude_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "/intrude_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "/intrude_busy"}, 64'(busy), 64'(1));
      end else begin
        tick();
      end
      cyc++;
      if (busy) busy_cnt++;
    end
    if (cyc > 100) check({tag, "/timeout"}, 64'(done), 64'(1));
    check({tag, "/latency"}, 64'(cyc), 64'(lat));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({tag, "/busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "/hi"}, 64'(hi), 64'(eh));
    check({tag, "/lo"}, 64'(lo), 64'(el));
    check({tag, "/div_zero"}, 64'(div_zero), 64'(edz));
    m_hi = eh; m_lo = el; m_dz = edz;
    tick();
    check({tag, "/done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    int           sel;

    // Reset release and idle
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("reset/hi", 64'(hi), 64'(0));
    check("reset/lo", 64'(lo), 64'(0));
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/div_zero", 64'(div_zero), 64'(0));

    // Directed operations
    run_op(4'b1100, 32'hFFFF_FFFE, 32'h3, "mult_neg2x3", 1'b0, 0);
    run_op(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 0);
    run_op(4'b1110, 32'hFFFF_FFF9, 32'h2, "div_m7_2", 1'b0, 0);
    run_op(4'b1111, 32'h7, 32'h2, "divu_7_2", 1'b0, 0);
    run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0, 0);
    run_op(4'b1111, 32'h1234, 32'h0, "divu_zero", 1'b0, 0);

    // Invalid op: ignored, sticky div_zero untouched
    start = 1'b1; op = 4'b0101; a = 32'h9; b = 32'h3;
    tick();
    start = 1'b0;
    check("badop/busy", 64'(busy), 64'(0));
    tick();
    check("badop/done", 64'(done), 64'(0));
    check("badop/div_zero_sticky", 64'(div_zero), 64'(m_dz));
    check("badop/hi", 64'(hi), 64'(m_hi));

    // mthi / mtlo while idle
    hi_we = 1'b1; wdata = 32'h0000_0055;
    tick();
    hi_we = 1'b0; m_hi = 32'h0000_0055;
    check("mthi", 64'(hi), 64'(m_hi));
    lo_we = 1'b1; wdata = 32'h0000_0066;
    tick();
    lo_we = 1'b0; m_lo = 32'h0000_0066;
    check("mtlo", 64'(lo), 64'(m_lo));

    // Same-edge start + mthi, then an ignored start + mthi/mtlo mid-operation
    run_op(4'b1100, 32'h5, 32'h6, "mult_with_mthi", 1'b1, 0);
    run_op(4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, "multu_intrude", 1'b0, 10);
    run_op(4'b1110, 32'h7FFF_FFFF, 32'hFFFF_FFFD, "div_intrude", 1'b0, 5);

    // Reset mid-operation aborts and clears HI/LO
    start = 1'b1; op = 4'b1100; a = 32'h0001_0001; b = 32'h0000_0777;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("abort/busy_before", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort/hi", 64'(hi), 64'(0));
    check("abort/lo", 64'(lo), 64'(0));
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/done", 64'(done), 64'(0));
    tick();
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (20) tick();
    check("abort/no_late_result_hi", 64'(hi), 64'(0));
    check("abort/no_late_result_lo", 64'(lo), 64'(0));
    check("abort/no_late_done", 64'(busy), 64'(0));

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro  = 4'(12 + $urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      ra  = (sel == 7) ? 32'h8000_0000 : 32'($urandom);
      case (sel)
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0h", i, ro), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
